winograd_accumulator: RTL and testbench

Result collector on the output side of the Winograd datapath. Each valid cycle it takes the two redundant (carry-save) operands produced by the 12:2 compressor stage, resolves them with a carry-propagate add and accumulates ACC_LEN consecutive results with signed saturation. It then pushes the finished sum into a small first-word-fall-through FIFO that is drained over a valid/ready interface. It also gives the upstream feeder a ready indication and flags dropped results.

---
 rtl/winograd_accumulator.sv | 162 ++++++++++++++++
 tb/tb_winograd_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_accumulator.sv
// winograd_accumulator: resolves the carry-save pair from the 12:2 compressor,
// accumulates ACC_LEN valid results with signed saturation and queues each
// finished sum in a first-word-fall-through FIFO drained over valid/ready.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         synchronous active-low reset
//   in_valid_i     in_0_i/in_1_i carry a valid redundant pair
//   in_0_i/in_1_i  redundant operands (IN_WIDTH)
//   in_ready_o     FIFO not full (advisory, upstream cannot stall)
//   out_valid_o    FIFO non-empty
//   out_ready_i    consumer accepts the head this cycle
//   out_data_o     FIFO head, signed result (ACC_WIDTH)
//   out_sat_o      saturation flag of the head result
//   err_overflow_o sticky: a finished result was dropped
module winograd_accumulator #(
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ACC_LEN    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    input  logic [IN_WIDTH-1:0]  in_0_i,
    input  logic [IN_WIDTH-1:0]  in_1_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_WIDTH-1:0] out_data_o,
    output logic                 out_sat_o,
    output logic                 err_overflow_o
);

    localparam int unsigned CntW   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned FillW  = PtrW + 1;
    localparam logic [CntW-1:0]      CntLast = CntW'(ACC_LEN - 1);
    localparam logic [FillW-1:0]     FillMax = FillW'(FIFO_DEPTH);
    localparam logic [ACC_WIDTH-1:0] MaxVal  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MinVal  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Resolve stage
    logic                res_valid_q;
    logic [IN_WIDTH-1:0] res_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            res_valid_q <= in_valid_i;
            if (in_valid_i) begin
                res_q <= in_0_i + in_1_i;
            end
        end
    end

    // Accumulate stage
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 sum_ovf;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 grp_done;

    // One guard bit: the two top bits disagree exactly on signed overflow.
    assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q}
                    + {{(ACC_WIDTH+1-IN_WIDTH){res_q[IN_WIDTH-1]}}, res_q};
    assign sum_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign sum_sat  = sum_ovf ? (sum_wide[ACC_WIDTH] ? MinVal : MaxVal)
                              : sum_wide[ACC_WIDTH-1:0];
    assign grp_done = res_valid_q && (cnt_q == CntLast);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (res_valid_q) begin
            if (grp_done) begin
                acc_d = '0;
                cnt_d = '0;
                sat_d = 1'b0;
            end else begin
                acc_d = sum_sat;
                cnt_d = cnt_q + CntW'(1);
                sat_d = sat_q | sum_ovf;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    // Result FIFO
    logic [ACC_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic                 mem_sat_q  [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [FillW-1:0]     fill_q, fill_d;
    logic                 fifo_full, fifo_empty;
    logic                 pop, push, drop;

    assign fifo_full  = (fill_q == FillMax);
    assign fifo_empty = (fill_q == '0);
    assign pop        = !fifo_empty && out_ready_i;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign push       = grp_done && (!fifo_full || pop);
    assign drop       = grp_done && fifo_full && !pop;

    always_comb begin
        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + FillW'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - FillW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            err_overflow_o <= 1'b0;
        end else begin
            fill_q <= fill_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (drop) begin
                err_overflow_o <= 1'b1;
            end
        end
    end

    // Storage needs no reset: every read is gated by the fill count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= sum_sat;
            mem_sat_q[wr_ptr_q]  <= sat_q | sum_ovf;
        end
    end

    assign in_ready_o  = !fifo_full;
    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_empty ? '0 : mem_data_q[rd_ptr_q];
    assign out_sat_o   = fifo_empty ? 1'b0 : mem_sat_q[rd_ptr_q];

endmodule

// File: tb/tb_winograd_accumulator.sv
// Bench for winograd_accumulator. Three instances share the stimulus:
//   dut_a: ACC_LEN=4 (default widths), dut_s: ACC_WIDTH=25/ACC_LEN=4,
//   dut_b: ACC_LEN=1/FIFO_DEPTH=4. Each test resets and checks one instance.
module tb_winograd_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] in_0, in_1;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_sat, a_err;
    logic [31:0] a_out_data;
    logic        s_in_ready, s_out_valid, s_out_sat, s_err;
    logic [24:0] s_out_data;
    logic        b_in_ready, b_out_valid, b_out_sat, b_err;
    logic [31:0] b_out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    winograd_accumulator #(.IN_WIDTH(24), .ACC_WIDTH(32), .ACC_LEN(4), .FIFO_DEPTH(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_0_i(in_0), .in_1_i(in_1),
        .in_ready_o(a_in_ready), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .out_data_o(a_out_data), .out_sat_o(a_out_sat), .err_overflow_o(a_err)
    );

    winograd_accumulator #(.IN_WIDTH(24), .ACC_WIDTH(25), .ACC_LEN(4), .FIFO_DEPTH(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_0_i(in_0), .in_1_i(in_1),
        .in_ready_o(s_in_ready), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .out_data_o(s_out_data), .out_sat_o(s_out_sat), .err_overflow_o(s_err)
    );

    winograd_accumulator #(.IN_WIDTH(24), .ACC_WIDTH(32), .ACC_LEN(1), .FIFO_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_0_i(in_0), .in_1_i(in_1),
        .in_ready_o(b_in_ready), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
        .out_data_o(b_out_data), .out_sat_o(b_out_sat), .err_overflow_o(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [23:0] x0, input logic [23:0] x1);
        in_valid = v;
        in_0     = x0;
        in_1     = x1;
        step();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_0      = '0;
        in_1      = '0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", a_out_valid); end
        n_cmp++; if (a_out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", a_out_data); end
        n_cmp++; if (a_out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b exp 0", a_out_sat); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", a_err); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
        n_cmp++; if ({s_out_valid, s_err, s_in_ready} !== 3'b001) begin n_fail++; $display("FAIL reset_s got %b exp 001", {s_out_valid, s_err, s_in_ready}); end
        n_cmp++; if ({b_out_valid, b_err, b_in_ready} !== 3'b001) begin n_fail++; $display("FAIL reset_b got %b exp 001", {b_out_valid, b_err, b_in_ready}); end
    endtask

    task automatic test_basic_sum();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 24'd5, 24'd3);
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got %b exp 0", a_out_valid); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", a_out_valid); end
        n_cmp++; if (a_out_data !== 32'd32) begin n_fail++; $display("FAIL basic_data got %0d exp 32", a_out_data); end
        n_cmp++; if (a_out_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat got %b exp 0", a_out_sat); end
        step();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle got %b exp 0", a_out_valid); end
    endtask

    task automatic test_sign_wrap();
        logic [31:0] got[$];
        int          at[$];
        do_reset();
        out_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 4)      drive(1'b1, 24'hFFFFFF, 24'h0);
            else if (c <= 8) drive(1'b1, 24'h800000, 24'h800000);
            else             drive(1'b0, 24'h0, 24'h0);
            if (a_out_valid) begin got.push_back(a_out_data); at.push_back(c); end
        end
        n_cmp++; if (got.size() !== 2) begin n_fail++; $display("FAIL wrap_count got %0d exp 2", got.size()); end
        if (got.size() == 2) begin
            n_cmp++; if (got[0] !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_a got %h exp fffffffc", got[0]); end
            n_cmp++; if (got[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_b got %h exp 0", got[1]); end
            n_cmp++; if (at[1] - at[0] !== 4) begin n_fail++; $display("FAIL wrap_spacing got %0d exp 4", at[1] - at[0]); end
        end
    endtask

    task automatic test_saturation();
        logic [25:0] got[$];
        do_reset();
        out_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 4)      drive(1'b1, 24'h7FFFFF, 24'h0);
            else if (c <= 8) drive(1'b1, 24'h1, 24'h0);
            else             drive(1'b0, 24'h0, 24'h0);
            if (s_out_valid) got.push_back({s_out_sat, s_out_data});
        end
        n_cmp++; if (got.size() !== 2) begin n_fail++; $display("FAIL sat_count got %0d exp 2", got.size()); end
        if (got.size() == 2) begin
            n_cmp++; if (got[0] !== {1'b1, 25'h0FFFFFF}) begin n_fail++; $display("FAIL sat_first got %h exp %h", got[0], {1'b1, 25'h0FFFFFF}); end
            n_cmp++; if (got[1] !== {1'b0, 25'd4}) begin n_fail++; $display("FAIL sat_second got %h exp %h", got[1], {1'b0, 25'd4}); end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] got[$];
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drive((c < 7) && (c % 2 == 0), 24'd1, 24'd0);
            if (a_out_valid) got.push_back(a_out_data);
        end
        n_cmp++; if (got.size() !== 1) begin n_fail++; $display("FAIL gaps_count got %0d exp 1", got.size()); end
        if (got.size() == 1) begin
            n_cmp++; if (got[0] !== 32'd4) begin n_fail++; $display("FAIL gaps_data got %0d exp 4", got[0]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 1; k <= 5; k++) drive(1'b1, 24'(k), 24'd0);
        n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b exp 0", b_in_ready); end
        n_cmp++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL bp_err_early got %b exp 0", b_err); end
        drive(1'b0, 24'd0, 24'd0);
        n_cmp++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL bp_err got %b exp 1", b_err); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({b_out_valid, b_out_data} !== {1'b1, 32'(i + 1)}) begin
                n_fail++; $display("FAIL bp_drain%0d got %b/%0d exp 1/%0d", i, b_out_valid, b_out_data, i + 1);
            end
            step();
            if (i == 0) begin
                n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %b exp 1", b_in_ready); end
            end
        end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", b_out_valid); end
        n_cmp++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL bp_err_sticky got %b exp 1", b_err); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int k = 1; k <= 5; k++) drive(1'b1, 24'(k), 24'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_cmp++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL fpp_err got %b exp 0", b_err); end
        n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL fpp_still_full got %b exp 0", b_in_ready); end
        for (int i = 2; i <= 5; i++) begin
            n_cmp++; if ({b_out_valid, b_out_data} !== {1'b1, 32'(i)}) begin
                n_fail++; $display("FAIL fpp_drain%0d got %b/%0d exp 1/%0d", i, b_out_valid, b_out_data, i);
            end
            step();
        end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty got %b exp 0", b_out_valid); end
    endtask

    task automatic test_reset_mid_group();
        logic [31:0] got[$];
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 24'd7, 24'd0);
        drive(1'b1, 24'd7, 24'd0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if ({a_out_valid, a_out_data, a_out_sat, a_err, a_in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rmg_zero got %b/%h/%b/%b/%b exp 0/0/0/0/1", a_out_valid, a_out_data, a_out_sat, a_err, a_in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            drive(c < 4, 24'd1, 24'd0);
            if (a_out_valid) got.push_back(a_out_data);
        end
        n_cmp++; if (got.size() !== 1) begin n_fail++; $display("FAIL rmg_count got %0d exp 1", got.size()); end
        if (got.size() == 1) begin
            n_cmp++; if (got[0] !== 32'd4) begin n_fail++; $display("FAIL rmg_data got %0d exp 4", got[0]); end
        end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rmg_err got %b exp 0", a_err); end
    endtask

    // Random traffic on dut_s against a group-level model of the sum and FIFO.
    task automatic test_random();
        localparam longint Max = (longint'(1) << 24) - 1;
        localparam longint Min = -(longint'(1) << 24);
        logic [25:0] m_q[$];
        bit          m_sv = 0, m_sat = 0, m_err = 0, pop, full;
        longint      m_x = 0, m_acc = 0, x;
        int          m_cnt = 0;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_0      = 24'($urandom);
            in_1      = 24'($urandom);
            out_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (i >= 450) in_valid = 1'b0;
            pop  = (m_q.size() != 0) && out_ready;
            full = (m_q.size() == 4);
            step();
            if (pop) void'(m_q.pop_front());
            if (m_sv) begin
                m_acc = m_acc + m_x;
                if (m_acc > Max) begin m_acc = Max; m_sat = 1; end
                if (m_acc < Min) begin m_acc = Min; m_sat = 1; end
                m_cnt++;
                if (m_cnt == 4) begin
                    if (!full || pop) m_q.push_back({m_sat, 25'(m_acc)});
                    else m_err = 1;
                    m_acc = 0; m_cnt = 0; m_sat = 0;
                end
            end
            m_sv = in_valid;
            if (in_valid) begin
                x   = (longint'(in_0) + longint'(in_1)) % (longint'(1) << 24);
                m_x = (x >= (longint'(1) << 23)) ? x - (longint'(1) << 24) : x;
            end
            n_cmp++; if (s_out_valid !== (m_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, s_out_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                n_cmp++; if ({s_out_sat, s_out_data} !== m_q[0]) begin
                    n_fail++; $display("FAIL rnd_head cyc %0d got %h exp %h", i, {s_out_sat, s_out_data}, m_q[0]);
                end
            end
            n_cmp++; if (s_in_ready !== (m_q.size() != 4)) begin
                n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", i, s_in_ready, m_q.size() != 4);
            end
            n_cmp++; if (s_err !== m_err) begin
                n_fail++; $display("FAIL rnd_err cyc %0d got %b exp %b", i, s_err, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_sign_wrap();
        test_saturation();
        test_gaps();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid_group();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
